// File: rtl/reg_seq_pkg.sv
// Shared definitions for the register-file sequencer.
// Op codes, FSM state codes and register-file geometry.
package reg_seq_pkg;

  localparam int NUM_REGS = 8;
  localparam int ADDR_W   = 3;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_LDI = 2'b11;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD1  = 3'd1;
  localparam logic [2:0] S_RD2  = 3'd2;
  localparam logic [2:0] S_EXEC = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;

endpackage

// File: rtl/seq_alu.sv
// Combinational ALU for the sequencer.
// Modulo-2^Width add, subtract and bitwise AND.
module seq_alu
  import reg_seq_pkg::*;
#(
  parameter int Width = 16
) (
  input  logic [1:0]       op,
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  output logic [Width-1:0] y
);

  always_comb begin
    y = '0;
    unique case (1'b1)
      (op == OP_ADD): y = a + b;
      (op == OP_SUB): y = a - b;
      (op == OP_AND): y = a & b;
      default:        y = '0;
    endcase
  end

endmodule

// File: rtl/reg_file_sequencer.sv
// Register-file sequencer: two reads through one
// registered port, ALU, then a single writeback.
module reg_file_sequencer
  import reg_seq_pkg::*;
#(
  parameter int Width = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [Width-1:0]  imm,
  output logic              read_enable,
  output logic [ADDR_W-1:0] read_addr,
  input  logic [Width-1:0]  read_data_external,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_addr,
  output logic [Width-1:0]  write_data,
  output logic              done,
  output logic [Width-1:0]  result
);

  logic [2:0]        state;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [ADDR_W-1:0] rs2_q;
  logic [Width-1:0]  opa;
  logic [Width-1:0]  alu_y;

  // opB is taken straight off the read port in EXEC
  seq_alu #(.Width(Width)) u_alu (
    .op (op_q),
    .a  (opa),
    .b  (read_data_external),
    .y  (alu_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      instr_ready  <= 1'b0;
      op_q         <= OP_ADD;
      rd_q         <= '0;
      rs2_q        <= '0;
      opa          <= '0;
      read_enable  <= 1'b0;
      read_addr    <= '0;
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
      done         <= 1'b0;
      result       <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          instr_ready <= 1'b1;
          if (instr_valid && instr_ready) begin
            instr_ready <= 1'b0;
            op_q        <= op;
            rd_q        <= rd;
            rs2_q       <= rs2;
            if (op == OP_LDI) begin
              write_data   <= imm;
              result       <= imm;
              write_addr   <= rd;
              write_enable <= 1'b1;
              done         <= 1'b1;
              state        <= S_WB;
            end else begin
              read_enable <= 1'b1;
              read_addr   <= rs1;
              state       <= S_RD1;
            end
          end
        end
        S_RD1: begin
          read_addr <= rs2_q;
          state     <= S_RD2;
        end
        S_RD2: begin
          opa         <= read_data_external;
          read_enable <= 1'b0;
          state       <= S_EXEC;
        end
        S_EXEC: begin
          write_data   <= alu_y;
          result       <= alu_y;
          write_addr   <= rd_q;
          write_enable <= 1'b1;
          done         <= 1'b1;
          state        <= S_WB;
        end
        S_WB: begin
          write_enable <= 1'b0;
          done         <= 1'b0;
          instr_ready  <= 1'b1;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_sequencer.sv
// Bench for reg_file_sequencer: behavioural register file,
// architectural register model, directed plus random ops.
module tb_reg_file_sequencer;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] AND = 2'b10;
  localparam logic [1:0] LDI = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [1:0]  op = 2'b00;
  logic [2:0]  rd = 3'd0;
  logic [2:0]  rs1 = 3'd0;
  logic [2:0]  rs2 = 3'd0;
  logic [15:0] imm = 16'h0;
  logic        read_enable;
  logic [2:0]  read_addr;
  wire  [15:0] read_data_external;
  logic        write_enable;
  logic [2:0]  write_addr;
  logic [15:0] write_data;
  logic        done;
  logic [15:0] result;

  int checks = 0;
  int failures = 0;
  int we_cnt = 0;

  logic [15:0] rf [8];
  logic [15:0] rq;
  logic        rv;
  logic [15:0] arch [8];

  always #5 clk = ~clk;

  reg_file_sequencer #(.Width(16)) dut (
    .clk                (clk),
    .rst                (rst),
    .instr_valid        (instr_valid),
    .instr_ready        (instr_ready),
    .op                 (op),
    .rd                 (rd),
    .rs1                (rs1),
    .rs2                (rs2),
    .imm                (imm),
    .read_enable        (read_enable),
    .read_addr          (read_addr),
    .read_data_external (read_data_external),
    .write_enable       (write_enable),
    .write_addr         (write_addr),
    .write_data         (write_data),
    .done               (done),
    .result             (result)
  );

  // register file: registered read, negedge write
  always @(posedge clk) begin
    if (rst) begin
      rv <= 1'b0;
    end else begin
      rv <= read_enable;
      if (read_enable) rq <= rf[read_addr];
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'h0;
    end else if (write_enable) begin
      rf[write_addr] <= write_data;
    end
  end

  assign read_data_external = rv ? rq : 16'bz;

  always @(posedge clk) if (write_enable) we_cnt++;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] model(input logic [1:0] o,
                                        input logic [15:0] a,
                                        input logic [15:0] b,
                                        input logic [15:0] im);
    case (o)
      ADD:     return a + b;
      SUB:     return a - b;
      AND:     return a & b;
      default: return im;
    endcase
  endfunction

  task automatic run(input logic [1:0] o, input logic [2:0] d,
                     input logic [2:0] s1, input logic [2:0] s2,
                     input logic [15:0] im);
    int n;
    int lat;
    logic [15:0] want;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(n < 20), 32'd1);
    want = model(o, arch[s1], arch[s2], im);
    instr_valid = 1'b1;
    op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
    @(posedge clk); #1;
    lat = 1;
    if (o != LDI) begin
      chk("rd_en", 32'(read_enable), 32'd1);
      chk("raddr1", 32'(read_addr), 32'(s1));
      chk("busy_ready", 32'(instr_ready), 32'd0);
      @(posedge clk); #1;
      lat = 2;
      chk("raddr2", 32'(read_addr), 32'(s2));
    end
    while (!done && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), (o == LDI) ? 32'd1 : 32'd4);
    chk("result", 32'(result), 32'(want));
    chk("waddr", 32'(write_addr), 32'(d));
    chk("we", 32'(write_enable), 32'd1);
    chk("result_xz", 32'($isunknown(result)), 32'd0);
    instr_valid = 1'b0;
    arch[d] = want;
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 32'd0);
    chk("we_off", 32'(write_enable), 32'd0);
    chk("ready_back", 32'(instr_ready), 32'd1);
    chk("rf_write", 32'(rf[d]), 32'(arch[d]));
    chk("result_hold", 32'(result), 32'(want));
  endtask

  initial begin
    int base;
    logic [1:0] ro;
    for (int i = 0; i < 8; i++) arch[i] = 16'h0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(instr_ready), 32'd0);
    chk("rst_ren", 32'(read_enable), 32'd0);
    chk("rst_we", 32'(write_enable), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_raddr", 32'(read_addr), 32'd0);
    chk("rst_waddr", 32'(write_addr), 32'd0);
    chk("rst_wdata", 32'(write_data), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(instr_ready), 32'd1);

    run(LDI, 3'd3, 3'd0, 3'd0, 16'h1234);
    run(LDI, 3'd1, 3'd0, 3'd0, 16'h0005);
    run(LDI, 3'd2, 3'd0, 3'd0, 16'h0003);
    run(ADD, 3'd4, 3'd1, 3'd2, 16'h0);
    run(SUB, 3'd5, 3'd2, 3'd1, 16'h0);
    chk("sub_neg", 32'(rf[5]), 32'h0000fffe);
    run(LDI, 3'd1, 3'd0, 3'd0, 16'hffff);
    run(LDI, 3'd2, 3'd0, 3'd0, 16'h0002);
    run(ADD, 3'd0, 3'd1, 3'd2, 16'h0);
    chk("add_wrap", 32'(rf[0]), 32'h00000001);
    run(LDI, 3'd1, 3'd0, 3'd0, 16'hf0f0);
    run(LDI, 3'd2, 3'd0, 3'd0, 16'h0ff0);
    run(AND, 3'd6, 3'd1, 3'd2, 16'h0);
    chk("and_mask", 32'(rf[6]), 32'h000000f0);
    run(LDI, 3'd1, 3'd0, 3'd0, 16'h0005);
    run(ADD, 3'd1, 3'd1, 3'd1, 16'h0);
    chk("dep1", 32'(rf[1]), 32'h0000000a);
    run(ADD, 3'd1, 3'd1, 3'd1, 16'h0);
    chk("dep2", 32'(rf[1]), 32'h00000014);

    // abort an ADD while it sits in EXEC
    @(negedge clk);
    instr_valid = 1'b1;
    op = ADD; rd = 3'd6; rs1 = 3'd1; rs2 = 3'd2;
    repeat (3) @(posedge clk);
    #1;
    base = we_cnt;
    rst = 1'b1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_we", 32'(write_enable), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_ren", 32'(read_enable), 32'd0);
    chk("abort_ready", 32'(instr_ready), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_wdata", 32'(write_data), 32'd0);
    chk("abort_raddr", 32'(read_addr), 32'd0);
    chk("abort_waddr", 32'(write_addr), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) arch[i] = 16'h0;
    @(posedge clk); #1;
    chk("abort_ready1", 32'(instr_ready), 32'd1);
    chk("abort_no_write", 32'(we_cnt - base), 32'd0);

    run(LDI, 3'd7, 3'd0, 3'd0, 16'h0021);
    run(ADD, 3'd7, 3'd7, 3'd7, 16'h0);
    chk("same_src", 32'(rf[7]), 32'h00000042);

    for (int k = 0; k < 40; k++) begin
      ro = 2'($urandom_range(0, 3));
      run(ro, 3'($urandom_range(0, 7)),
          3'($urandom_range(0, 7)),
          3'($urandom_range(0, 7)),
          16'($urandom));
    end
    for (int i = 0; i < 8; i++) chk("final_rf", 32'(rf[i]), 32'(arch[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
